// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_pkg                                                                   |
// | Shared types and constants for the 5-stage pipeline front end.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DROP   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_hold_buf                                                             |
// | One-entry skid register holding a fetched PC+4/instruction pair while      |
// | IF/ID is stalled. Priority: flush > consume > load.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_hold_buf
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        i_load,
  input  logic        i_consume,
  input  logic        i_flush,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_ir,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_ir
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_ir;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_valid <= 1'b0;
      r_pc    <= C_NOP;
      r_ir    <= C_NOP;
    end else if (i_flush || i_consume) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_ir    <= i_ir;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_ir    = r_ir;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage                                                                |
// | Instruction fetch: owns the PC, runs the imem req/rdy handshake and feeds  |
// | IF/ID. Optional FETCH_PERF_CNT_EN adds fetch_cnt/stall_cnt counters.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               Enable,
  input  logic               Redirect,
  input  logic [31:0]        Redirect_PC,
  input  logic               Halt_IN,
  input  logic               Resume,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_rdy,
  input  logic [31:0]        imem_data,
  output logic [31:0]        PC_OUT,
  output logic [31:0]        IR_OUT,
  output logic               Bubble_OUT,
  output logic               Halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_target, w_target_nxt;
  logic         r_live;
  logic         r_halt_pend, w_halt_pend_nxt;

  logic         w_hb_valid;
  logic [31:0]  w_hb_pc;
  logic [31:0]  w_hb_ir;

  logic         w_req, w_xfer, w_stall, w_deliver_new, w_halt_req;
  logic [31:0]  w_pc_plus4, w_redir_pc;

  // r_live holds off the first request until the first edge after reset release.
  assign w_req         = r_live && !w_hb_valid && (r_state != ST_HALTED);
  assign w_xfer        = w_req && imem_rdy;
  assign w_stall       = w_req && !imem_rdy;
  assign w_deliver_new = w_xfer && (r_state != ST_DROP) && !Redirect;
  assign w_halt_req    = Halt_IN || r_halt_pend;
  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_redir_pc    = word_align(Redirect_PC);

  fetch_hold_buf u_hold_buf (
    .clk       (clk),
    .clr_n     (clr_n),
    .i_load    (w_deliver_new && !Enable),
    .i_consume (w_hb_valid && Enable),
    .i_flush   (Redirect),
    .i_pc      (w_pc_plus4),
    .i_ir      (imem_data),
    .o_valid   (w_hb_valid),
    .o_pc      (w_hb_pc),
    .o_ir      (w_hb_ir)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_target    <= C_NOP;
      r_live      <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_target    <= w_target_nxt;
      r_live      <= 1'b1;
      r_halt_pend <= w_halt_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_target_nxt    = r_target;
    w_halt_pend_nxt = r_halt_pend || Halt_IN;
    unique case (r_state)
      ST_FETCH, ST_WAIT: begin
        if (w_stall) begin
          // A redirect cannot abandon a request mid-handshake; drain it in DROP.
          if (Redirect) begin
            w_state_nxt  = ST_DROP;
            w_target_nxt = w_redir_pc;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else begin
          if (Redirect) begin
            w_pc_nxt = w_redir_pc;
          end else if (w_xfer) begin
            w_pc_nxt = w_pc_plus4;
          end
          w_state_nxt = w_halt_req ? ST_HALTED : ST_FETCH;
        end
      end
      ST_DROP: begin
        if (w_xfer) begin
          w_pc_nxt    = Redirect ? w_redir_pc : r_target;
          w_state_nxt = w_halt_req ? ST_HALTED : ST_FETCH;
        end else if (Redirect) begin
          w_target_nxt = w_redir_pc;
        end
      end
      ST_HALTED: begin
        if (Redirect) begin
          w_pc_nxt = w_redir_pc;
        end
        if (Resume && !Halt_IN) begin
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_FETCH;
    endcase
    if (w_state_nxt == ST_HALTED) begin
      w_halt_pend_nxt = 1'b0;
    end
  end

  always_comb begin
    Bubble_OUT = 1'b1;
    PC_OUT     = C_NOP;
    IR_OUT     = C_NOP;
    if (!Redirect) begin
      if (w_hb_valid) begin
        Bubble_OUT = 1'b0;
        PC_OUT     = w_hb_pc;
        IR_OUT     = w_hb_ir;
      end else if (w_deliver_new) begin
        Bubble_OUT = 1'b0;
        PC_OUT     = w_pc_plus4;
        IR_OUT     = imem_data;
      end
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc[IMEM_AW+1:2];
  assign Halted    = (r_state == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (!Bubble_OUT && Enable) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_stage                                                             |
// | Directed bench for fetch_stage with a delivery scoreboard.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

  localparam int IMEM_AW = 10;

  logic               clk = 1'b0;
  logic               clr_n = 1'b0;
  logic               Enable = 1'b1;
  logic               Redirect = 1'b0;
  logic [31:0]        Redirect_PC = 32'h0;
  logic               Halt_IN = 1'b0;
  logic               Resume = 1'b0;
  logic               imem_rdy = 1'b1;
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic [31:0]        PC_OUT;
  logic [31:0]        IR_OUT;
  logic               Bubble_OUT;
  logic               Halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        fetch_cnt;
  logic [31:0]        stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } xfer_t;
  xfer_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [IMEM_AW-1:0] a);
    return 32'hC0DE_0000 | {22'h0, a};
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .IMEM_AW  (IMEM_AW)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .Enable      (Enable),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC),
    .Halt_IN     (Halt_IN),
    .Resume      (Resume),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .PC_OUT      (PC_OUT),
    .IR_OUT      (IR_OUT),
    .Bubble_OUT  (Bubble_OUT),
    .Halted      (Halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ir);
    xfer_t e;
    e.pc = pc;
    e.ir = ir;
    exp_q.push_back(e);
  endtask

  // Monitor: every word accepted by IF/ID must match the next scoreboard entry.
  always @(negedge clk) begin
    xfer_t e;
    if (clr_n) begin
      if (!Bubble_OUT && Enable) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL deliver_unexpected: got pc %h ir %h expected none", PC_OUT, IR_OUT);
        end else begin
          e = exp_q.pop_front();
          if (PC_OUT !== e.pc || IR_OUT !== e.ir) begin
            errors++;
            $display("FAIL deliver: got pc %h ir %h expected pc %h ir %h",
                     PC_OUT, IR_OUT, e.pc, e.ir);
          end
        end
      end else if (Bubble_OUT) begin
        checks++;
        if (PC_OUT !== 32'h0 || IR_OUT !== 32'h0) begin
          errors++;
          $display("FAIL bubble_zero: got pc %h ir %h expected 0 0", PC_OUT, IR_OUT);
        end
      end
    end
  end

  initial begin
    // Reset values
    repeat (2) cyc();
    mid();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc_out", PC_OUT, 32'd0);
    chk("rst_ir_out", IR_OUT, 32'd0);
    chk("rst_bubble", 32'(Bubble_OUT), 32'd1);
    chk("rst_halted", 32'(Halted), 32'd0);
    cyc();
    clr_n = 1'b1;
    mid();
    chk("release_req", 32'(imem_req), 32'd0);

    // Back-to-back fetch with rdy tied high
    for (int i = 0; i < 4; i++) push(32'(4 * (i + 1)), mem_word(10'(i)));
    for (int i = 0; i < 4; i++) begin
      cyc();
      mid();
      chk("seq_addr", 32'(imem_addr), 32'(i));
      chk("seq_req", 32'(imem_req), 32'd1);
    end

    // IF/ID stall for 3 cycles
    cyc(); Enable = 1'b0; mid();
    chk("stall_addr", 32'(imem_addr), 32'd4);
    for (int i = 0; i < 2; i++) begin
      cyc(); mid();
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_pc", PC_OUT, 32'd20);
      chk("hold_ir", IR_OUT, mem_word(10'd4));
      chk("hold_bubble", 32'(Bubble_OUT), 32'd0);
    end
    push(32'd20, mem_word(10'd4));
    push(32'd24, mem_word(10'd5));
    cyc(); Enable = 1'b1; mid();
    chk("drain_req", 32'(imem_req), 32'd0);
    cyc(); mid();
    chk("drain_next_addr", 32'(imem_addr), 32'd5);

    // Slow memory, redirect in the first wait cycle
    cyc(); imem_rdy = 1'b0; mid();
    chk("wait_addr", 32'(imem_addr), 32'd6);
    chk("wait_bubble", 32'(Bubble_OUT), 32'd1);
    cyc(); Redirect = 1'b1; Redirect_PC = 32'h0000_0100; mid();
    chk("redir_wait_bubble", 32'(Bubble_OUT), 32'd1);
    chk("redir_wait_req", 32'(imem_req), 32'd1);
    cyc(); Redirect = 1'b0; imem_rdy = 1'b1; mid();
    chk("drop_addr", 32'(imem_addr), 32'd6);
    chk("drop_bubble", 32'(Bubble_OUT), 32'd1);
    push(32'h104, mem_word(10'h40));
    cyc(); mid();
    chk("redir_addr", 32'(imem_addr), 32'h40);

    // Redirect coinciding with rdy=1, low address bits ignored
    cyc(); Redirect = 1'b1; Redirect_PC = 32'h0000_0203; mid();
    chk("redir_rdy_bubble", 32'(Bubble_OUT), 32'd1);
    push(32'h204, mem_word(10'h80));
    cyc(); Redirect = 1'b0; mid();
    chk("redir_rdy_addr", 32'(imem_addr), 32'h80);

    // Halt with an outstanding fetch, then resume
    cyc(); Halt_IN = 1'b1; imem_rdy = 1'b0; mid();
    chk("halt_issue_addr", 32'(imem_addr), 32'h81);
    chk("halt_issue_halted", 32'(Halted), 32'd0);
    push(32'h208, mem_word(10'h81));
    cyc(); Halt_IN = 1'b0; imem_rdy = 1'b1; mid();
    chk("halt_wait_halted", 32'(Halted), 32'd0);
    cyc(); mid();
    chk("halted", 32'(Halted), 32'd1);
    chk("halted_req", 32'(imem_req), 32'd0);
    chk("halted_bubble", 32'(Bubble_OUT), 32'd1);
    cyc(); Resume = 1'b1; mid();
    chk("resume_cycle_halted", 32'(Halted), 32'd1);
    push(32'h20C, mem_word(10'h82));
    cyc(); Resume = 1'b0; mid();
    chk("resumed_halted", 32'(Halted), 32'd0);
    chk("resumed_addr", 32'(imem_addr), 32'h82);

    // Halt with rdy=1, then Halt_IN+Resume together stays halted
    push(32'h210, mem_word(10'h83));
    cyc(); Halt_IN = 1'b1; mid();
    cyc(); Resume = 1'b1; mid();
    chk("halt_resume_halted", 32'(Halted), 32'd1);
    chk("halt_resume_req", 32'(imem_req), 32'd0);
    cyc(); Halt_IN = 1'b0; Resume = 1'b0; mid();
    chk("halt_wins", 32'(Halted), 32'd1);
    cyc(); Resume = 1'b1; mid();
    // PC wrap at the top of the address space
    cyc(); Resume = 1'b0; Redirect = 1'b1; Redirect_PC = 32'hFFFF_FFFC; mid();
    chk("frozen_pc_addr", 32'(imem_addr), 32'h84);
    push(32'h0000_0000, mem_word(10'h3FF));
    push(32'h0000_0004, mem_word(10'h000));
    cyc(); Redirect = 1'b0; mid();
    chk("wrap_addr", 32'(imem_addr), 32'h3FF);
    cyc(); mid();
    chk("wrapped_addr", 32'(imem_addr), 32'h0);

    // Asynchronous reset during WAIT
    cyc(); imem_rdy = 1'b0; mid();
    chk("pre_rst_addr", 32'(imem_addr), 32'd1);
    cyc(); mid();
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    clr_n = 1'b0;
    #1;
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_bubble", 32'(Bubble_OUT), 32'd1);
    chk("async_pc_out", PC_OUT, 32'd0);
    chk("async_ir_out", IR_OUT, 32'd0);
    chk("async_halted", 32'(Halted), 32'd0);
    chk("async_addr", 32'(imem_addr), 32'd0);
    cyc(); cyc();
    clr_n = 1'b1; imem_rdy = 1'b1;
    mid();
    chk("rerelease_req", 32'(imem_req), 32'd0);
    push(32'd4, mem_word(10'd0));
    cyc(); mid();
    chk("restart_addr", 32'(imem_addr), 32'd0);
    chk("restart_req", 32'(imem_req), 32'd1);
    cyc(); imem_rdy = 1'b0; mid();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch front end of the 5-stage pipeline, directly upstream of the IF/ID segment register. Owns the PC, issues word fetches to instruction memory over a req/rdy handshake, and presents PC+4 / instruction / bubble to IF/ID. Handles stalls from the hazard unit, branch/jump redirects resolved downstream, and a halt/resume state for the board-level run control.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_AW, 10, word-address width driven on imem_addr

Ports:
clk  in  1  pipeline clock, all state on rising edge
clr_n  in  1  asynchronous active-low reset
Enable  in  1  IF/ID accept; 0 = downstream stall, fetch holds its output
Redirect  in  1  taken branch/jump; flushes fetch
Redirect_PC  in  32  byte address of redirect target (bits[1:0] ignored)
Halt_IN  in  1  one-cycle pulse from ID: halt after current fetch
Resume  in  1  one-cycle pulse: leave HALTED
imem_req  out  1  fetch request
imem_addr  out  IMEM_AW  word address = PC[IMEM_AW+1:2]
imem_rdy  in  1  memory ack; imem_data valid in the same cycle
imem_data  in  32  instruction word
PC_OUT  out  32  fetched PC + 4, to IF/ID PC_IN
IR_OUT  out  32  instruction, to IF/ID IR_IN
Bubble_OUT  out  1  1 = no valid instruction this cycle, to IF/ID Bubble
Halted  out  1  1 while in HALTED

Behaviour:
- Reset (clr_n low, asynchronous): PC=RESET_PC, state=FETCH, hold buffer empty, pending redirect cleared; outputs imem_req=0, PC_OUT=0, IR_OUT=0, Bubble_OUT=1, Halted=0. First imem_req on the first edge after clr_n deasserts.
- States: FETCH, WAIT, DROP, HALTED.
- Handshake: imem_req and imem_addr stay stable from assertion until the cycle imem_rdy=1; transfer completes in that cycle. Combinational-rdy memory yields 1 instruction/cycle.
- FETCH: imem_req=1 if hold buffer empty. rdy=1 and Enable=1: output instruction (Bubble_OUT=0), PC<=PC+4. rdy=1 and Enable=0: write to hold buffer, PC<=PC+4. rdy=0: go WAIT.
- WAIT: keep req until rdy, then act as FETCH completion and return to FETCH.
- Hold buffer (1 entry): while full, imem_req=0; output its contents with Bubble_OUT=0 once Enable=1, then empty. With Enable=0, outputs stay stable.
- Redirect: highest priority. Clears hold buffer and sets Bubble_OUT=1 that cycle. With no outstanding request, PC<=Redirect_PC and stay in FETCH. If a request is outstanding (rdy=0 in WAIT/FETCH), store target, go DROP, keep req until rdy, discard data, then PC<=target and go FETCH. Redirect coinciding with rdy=1: discard data, PC<=Redirect_PC, no DROP. Redirect in DROP overwrites the stored target.
- Halt_IN: completes any outstanding transfer (buffered normally), then enters HALTED. In HALTED: imem_req=0, Bubble_OUT=1 (once hold buffer drains), Halted=1, PC frozen. Redirect in HALTED updates PC and stays HALTED. Resume returns to FETCH. Resume and Halt_IN together: Halt_IN wins.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. imem_addr is truncated to IMEM_AW bits.
- Bubble_OUT=1 means IR_OUT=0 and PC_OUT=0.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds output ports fetch_cnt[31:0] (instructions delivered with Bubble_OUT=0 and Enable=1) and stall_cnt[31:0] (cycles with imem_req=1 and imem_rdy=0). Both counters wrap and reset to 0 on clr_n. When undefined, these ports and counters do not exist.

Decomposition:
- Shared package pipe_pkg: FSM state encoding (FETCH, WAIT, DROP, HALTED), RESET_PC default, NOP word 32'h0.
- Sub-module fetch_hold_buf: 1-entry valid/PC/IR holding register with load/consume/flush.

Test Plan:
- Reset with rdy tied 1 -> imem_addr 0,1,2... on consecutive cycles; PC_OUT 4,8,12; Bubble_OUT=0 from the first fetch.
- Enable=0 for 3 cycles while rdy=1 -> one word buffered, imem_req=0, outputs frozen; Enable=1 -> buffered word delivered next with no loss or duplicate.
- rdy delayed 2 cycles, Redirect to 32'h0000_0100 in the first wait cycle -> returned word discarded (Bubble_OUT=1), next imem_addr=0x40.
- Redirect together with rdy=1 -> data dropped, next imem_addr=Redirect_PC>>2.
- Halt_IN -> Halted=1, imem_req=0 after the outstanding fetch; Resume -> fetching restarts at the frozen PC.
- Assert clr_n low mid-WAIT -> all outputs return to reset values immediately (asynchronously); first fetch after release is at RESET_PC.
